// File: rtl/mem_stage_access.sv
// ---------------------------------------------------------------------------
// mem_stage_access
//
// The MEM stage of the pipeline. It takes the registered EX/MEM fields and
// performs the data-memory access over a valid/ack port. While an access is
// outstanding it holds the upstream pipeline. Load data is aligned and
// extended here. The MEM/WB register at the end feeds writeback.
//
// Parameters
//   TIMEOUT        number of BUSY cycles without dmem_ack before the access
//                  is abandoned with bus_err (2..255)
//
// Ports
//   clock, reset   system clock; synchronous active-high reset
//   MEM_*          EX/MEM register fields (address/ALU result, store data,
//                  destination, control bits, access size, unsigned load)
//   dmem_*         data-memory request port (req/we/addr/be/wdata out,
//                  ack/rdata in)
//   stall          combinational hold for PC, IF/ID, ID/EX and EX/MEM
//   WB_*           registered writeback fields
//   misalign       one-cycle pulse: misaligned access dropped
//   bus_err        one-cycle pulse: access timed out
// ---------------------------------------------------------------------------
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_D2,
  input  logic [4:0]  MEM_RD,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_Size,
  input  logic        MEM_Unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_Data,
  output logic        WB_RegWrite,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tcount;

  logic        access;
  logic        is_load;
  logic        aligned;
  logic        timeout_hit;
  logic [1:0]  a;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] wb_data_next;

  // NOTE: every signal written in this always_comb gets a value before any
  // branch. A path that leaves one unassigned would infer a latch.
  always_comb begin
    access       = MEM_MemRead | MEM_MemWrite;
    // A read+write combination is handled as a write.
    is_load      = MEM_MemRead & ~MEM_MemWrite;
    a            = MEM_ALUResult[1:0];
    aligned      = 1'b1;
    be_next      = 4'b1111;
    wdata_next   = MEM_D2;
    load_data    = dmem_rdata;

    byte_sel     = 8'(dmem_rdata >> {a, 3'b000});
    half_sel     = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    unique case (MEM_Size)
      2'b00: begin
        be_next    = 4'b0001 << a;
        wdata_next = {4{MEM_D2[7:0]}};
        load_data  = MEM_Unsigned ? {24'h0, byte_sel}
                                  : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        aligned    = ~a[0];
        be_next    = a[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{MEM_D2[15:0]}};
        load_data  = MEM_Unsigned ? {16'h0, half_sel}
                                  : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        // Size 2'b11 behaves as a word access.
        aligned    = (a == 2'b00);
      end
    endcase

    wb_data_next = is_load ? load_data : MEM_ALUResult;

    timeout_hit  = (state == BUSY) && !dmem_ack && (tcount == TLAST);

    // The stall drops in the ack cycle. EX/MEM then advances at the same
    // edge that retires the access, so the instruction is never re-issued.
    stall        = ((state == IDLE) && access && aligned) ||
                   ((state == BUSY) && !dmem_ack && !timeout_hit);
  end

  // NOTE: sequential state uses non-blocking assignments only. That way
  // every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tcount      <= 8'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      WB_RD       <= 5'd0;
      WB_Data     <= 32'h0;
      WB_RegWrite <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;

      if (state == IDLE) begin
        if (access && !aligned) begin
          // Drop the access. Nothing is requested and nothing is written back.
          misalign    <= 1'b1;
          WB_RD       <= MEM_RD;
          WB_RegWrite <= 1'b0;
          WB_Data     <= 32'h0;
        end else if (access) begin
          dmem_req    <= 1'b1;
          dmem_we     <= MEM_MemWrite;
          dmem_addr   <= {MEM_ALUResult[31:2], 2'b00};
          dmem_be     <= be_next;
          dmem_wdata  <= wdata_next;
          tcount      <= 8'd0;
          state       <= BUSY;
          WB_RegWrite <= 1'b0;          // bubble while the access is pending
        end else begin
          WB_RD       <= MEM_RD;
          WB_RegWrite <= MEM_RegWrite;
          WB_Data     <= MEM_ALUResult;
        end
      end else begin
        // BUSY: the dmem_* outputs stay put until the access ends.
        if (dmem_ack) begin
          dmem_req    <= 1'b0;
          WB_RD       <= MEM_RD;
          WB_RegWrite <= MEM_RegWrite;
          WB_Data     <= wb_data_next;
          state       <= IDLE;
        end else if (timeout_hit) begin
          dmem_req    <= 1'b0;
          bus_err     <= 1'b1;
          WB_RD       <= MEM_RD;
          WB_RegWrite <= 1'b0;
          WB_Data     <= 32'h0;
          state       <= IDLE;
        end else begin
          tcount      <= tcount + 8'd1;
          WB_RegWrite <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] MEM_ALUResult, MEM_D2;
  logic [4:0]  MEM_RD;
  logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Unsigned;
  logic [1:0]  MEM_Size;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall;
  logic [4:0]  WB_RD;
  logic [31:0] WB_Data;
  logic        WB_RegWrite, misalign, bus_err;

  mem_stage_access #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .MEM_ALUResult(MEM_ALUResult), .MEM_D2(MEM_D2), .MEM_RD(MEM_RD),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_Size(MEM_Size),
    .MEM_Unsigned(MEM_Unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .WB_RD(WB_RD), .WB_Data(WB_Data),
    .WB_RegWrite(WB_RegWrite), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        mis;
    logic        berr;
  } wb_t;

  wb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return (a == 2'd0) || (a == 2'd2);
      default: return a == 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] a);
    if (size == 2'b00) begin
      case (a)
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (size == 2'b01) return (a == 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d2);
    if (size == 2'b00) return {d2[7:0], d2[7:0], d2[7:0], d2[7:0]};
    if (size == 2'b01) return {d2[15:0], d2[15:0]};
    return d2;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [1:0] a,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rdata;
  endfunction

  // Run one instruction through MEM, acting as the memory, until the stage
  // stops stalling. ack_after = number of BUSY cycles before the ack cycle;
  // a negative value means the memory never acknowledges.
  task automatic run(input string tag, input logic [31:0] alu, input logic [31:0] d2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                     input logic [1:0] size, input logic uns, input int ack_after,
                     input logic [31:0] rdata);
    wb_t  e;
    logic acc, ok, ld;
    int   stall_n, busy_n, exp_stall, exp_busy;
    bit   done;
    acc = mr | mw;
    ld  = mr & ~mw;
    ok  = exp_aligned(size, alu[1:0]);
    e.rd = rd;
    e.mis = 1'b0;
    e.berr = 1'b0;
    if (acc && !ok) begin
      e.rw = 1'b0; e.data = 32'h0; e.mis = 1'b1;
    end else if (acc && ack_after < 0) begin
      e.rw = 1'b0; e.data = 32'h0; e.berr = 1'b1;
    end else begin
      e.rw = rw;
      e.data = ld ? exp_load(rdata, alu[1:0], size, uns) : alu;
    end
    sb.push_back(e);
    exp_stall = (acc && ok) ? 1 + ((ack_after < 0) ? TIMEOUT - 1 : ack_after) : 0;
    exp_busy  = (acc && ok) ? ((ack_after < 0) ? TIMEOUT : ack_after + 1) : 0;

    MEM_ALUResult = alu; MEM_D2 = d2; MEM_RD = rd; MEM_RegWrite = rw;
    MEM_MemRead = mr; MEM_MemWrite = mw; MEM_Size = size; MEM_Unsigned = uns;
    stall_n = 0; busy_n = 0; done = 0;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      dmem_ack   = dmem_req && (busy_n == ack_after);
      dmem_rdata = dmem_req ? rdata : 32'h5A5A_A5A5;
      #1;
      if (stall) stall_n++;
      if (dmem_req) begin
        busy_n++;
        check({tag, "_addr"},  dmem_addr, {alu[31:2], 2'b00});
        check({tag, "_we"},    32'(dmem_we), 32'(mw));
        check({tag, "_be"},    32'(dmem_be), 32'(exp_be(size, alu[1:0])));
        if (mw) check({tag, "_wdata"}, dmem_wdata, exp_wdata(size, d2));
      end
      done = !stall;
      @(posedge clock); #1;
      dmem_ack = 1'b0;
    end
    if (!done) check({tag, "_bound"}, 32'd0, 32'd1);
    check({tag, "_stalls"}, 32'(stall_n), 32'(exp_stall));
    check({tag, "_busy"},   32'(busy_n),  32'(exp_busy));

    e = sb.pop_front();
    check({tag, "_wb_rd"},  32'(WB_RD),       32'(e.rd));
    check({tag, "_wb_rw"},  32'(WB_RegWrite), 32'(e.rw));
    check({tag, "_wb_dat"}, WB_Data,          e.data);
    check({tag, "_mis"},    32'(misalign),    32'(e.mis));
    check({tag, "_berr"},   32'(bus_err),     32'(e.berr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  32'(dmem_req),    32'd0);
    check({tag, "_we"},   32'(dmem_we),     32'd0);
    check({tag, "_addr"}, dmem_addr,        32'd0);
    check({tag, "_be"},   32'(dmem_be),     32'd0);
    check({tag, "_wd"},   dmem_wdata,       32'd0);
    check({tag, "_rd"},   32'(WB_RD),       32'd0);
    check({tag, "_dat"},  WB_Data,          32'd0);
    check({tag, "_rw"},   32'(WB_RegWrite), 32'd0);
    check({tag, "_mis"},  32'(misalign),    32'd0);
    check({tag, "_berr"}, 32'(bus_err),     32'd0);
  endtask

  initial begin
    reset = 1'b1;
    MEM_ALUResult = '0; MEM_D2 = '0; MEM_RD = '0; MEM_RegWrite = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Size = 2'b10; MEM_Unsigned = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    //   tag      alu            d2             rd     rw    mr    mw    size   uns  ack  rdata
    run("alu",    32'h0000_1234, 32'h0,         5'd5,  1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
    run("lb",     32'h0000_0103, 32'h0,         5'd8,  1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h80FF_0000);
    run("lbu",    32'h0000_0103, 32'h0,         5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 0, 32'h80FF_0000);
    run("sh",     32'h0000_0202, 32'hAAAA_BEEF, 5'd0,  1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 3, 32'h0);
    run("lw_mis", 32'h0000_0101, 32'h0,         5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'h1111_1111);
    run("lh_mis", 32'h0000_0003, 32'h0,         5'd11, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 0, 32'h2222_2222);
    run("lhu",    32'h0000_0206, 32'h0,         5'd12, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1, 32'h8001_7FFF);
    run("lh",     32'h0000_0204, 32'h0,         5'd13, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 0, 32'h1234_F00D);
    run("sw",     32'h0000_0300, 32'hCAFE_F00D, 5'd0,  1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1, 32'h0);
    run("lw",     32'h0000_0400, 32'h0,         5'd14, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2, 32'h89AB_CDEF);
    run("sb",     32'h0000_0001, 32'h1234_565A, 5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 0, 32'h0);
    run("lw11",   32'h0000_0010, 32'h0,         5'd15, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0, 32'h0BAD_F00D);
    run("rdwr",   32'h0000_0020, 32'h7654_3210, 5'd16, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h0);
    run("tmo",    32'h0000_0500, 32'h0,         5'd17, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, -1, 32'h0);
    run("alu2",   32'hDEAD_0001, 32'h0,         5'd31, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);

    // Reset in the second BUSY cycle of a load, then an ack arriving in IDLE.
    MEM_ALUResult = 32'h0000_0600; MEM_RD = 5'd20; MEM_RegWrite = 1'b1;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_Size = 2'b10; MEM_Unsigned = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_busy_req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("rst_mid");
    reset = 1'b0;
    MEM_ALUResult = '0; MEM_RD = '0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;
    #1;
    check("rst_idle_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    check("late_ack_req", 32'(dmem_req),    32'd0);
    check("late_ack_rw",  32'(WB_RegWrite), 32'd0);
    check("late_ack_dat", WB_Data,          32'd0);

    run("alu3",   32'h0000_4321, 32'h0,         5'd7,  1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
    run("lb_rst", 32'h0000_0701, 32'h0,         5'd6,  1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h0000_7F00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
